// File: rtl/sw_seq_monitor_if.sv
// Record stream interface for sw_seq_monitor: one row record per transfer,
// moved on REC_VALID && REC_READY. DATA_W must match the monitor's record width.
interface sw_seq_monitor_if #(
  parameter int DATA_W = 27
);
  logic [DATA_W-1:0] REC_DATA;
  logic              REC_VALID;
  logic              REC_READY;

  modport master (output REC_DATA, output REC_VALID, input REC_READY);
  modport slave  (input REC_DATA, input REC_VALID, output REC_READY);
endinterface

// File: rtl/sw_seq_monitor.sv
// sw_seq_monitor: watches the 16-bit deserialized switcher word, tracks frame
// and row boundaries, measures GATE/CLEAR high time per row in 320 MHz sample
// units and emits one record per completed row.
// Optional build macro SW_SEQ_MONITOR_TIMESTAMP_EN appends a 16-bit row-open
// timestamp as the record LSBs.
module sw_seq_monitor #(
  parameter int ROW_W    = 10,
  parameter int WIDTH_W  = 8,
  parameter int MAX_ROWS = 768
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic [15:0]        SW_DES,
  input  logic               CLR_ERR,
  sw_seq_monitor_if.master   rec,
  output logic [15:0]        FRAME_CNT,
  output logic [ROW_W-1:0]   ROW_CNT,
  output logic               ERR_OVF,
  output logic               ERR_ROWS,
  output logic               ERR_GLITCH
);

`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
  localparam int REC_W = 17 + ROW_W + 2*WIDTH_W;
`else
  localparam int REC_W = 1 + ROW_W + 2*WIDTH_W;
`endif
  localparam logic [ROW_W:0] MAX_ROWS_C = (ROW_W+1)'(MAX_ROWS);

  typedef enum logic [1:0] {IDLE, WAIT_CLK, ROW, OVER} state_e;

  // Counts 0->1 transitions across the previous word's last sample and the nibble.
  function automatic logic [2:0] rise_count(input logic [3:0] nib, input logic prev);
    logic [4:0] ext;
    logic [2:0] n;
    ext = {nib, prev};
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (!ext[i] && ext[i+1]) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] nib);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, nib[i]};
    return n;
  endfunction

  function automatic logic [WIDTH_W-1:0] sat_add(input logic [WIDTH_W-1:0] acc,
                                                 input logic [2:0] inc);
    logic [WIDTH_W:0] s;
    s = {1'b0, acc} + (WIDTH_W+1)'(inc);
    return s[WIDTH_W] ? '1 : s[WIDTH_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic                prev_clk_q, prev_frame_q;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic [WIDTH_W-1:0]  gate_acc_q, gate_acc_d;
  logic [WIDTH_W-1:0]  clear_acc_q, clear_acc_d;
  logic                over_hit_q, over_hit_d;
  logic                rec_valid_q, rec_valid_d;
  logic [REC_W-1:0]    rec_data_q, rec_data_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_rows_q, err_rows_d;
  logic                err_glitch_q, err_glitch_d;
`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
  logic [15:0]         ts_q;
  logic [15:0]         ts_row_q, ts_row_d;
`endif

  logic [2:0]       clk_rises;
  logic             clk_edge, frame_edge;
  logic [2:0]       gate_pop, clear_pop;
  logic [ROW_W:0]   row_inc;
  logic             emit, rows_set, glitch_set, ovf_set;
  logic [REC_W-1:0] new_rec;

  assign clk_rises  = rise_count(SW_DES[3:0], prev_clk_q);
  assign clk_edge   = (clk_rises != 3'd0);
  assign frame_edge = (rise_count(SW_DES[7:4], prev_frame_q) != 3'd0);
  assign gate_pop   = pop4(SW_DES[11:8]);
  assign clear_pop  = pop4(SW_DES[15:12]);
  assign row_inc    = {1'b0, row_cnt_q} + (ROW_W+1)'(1);

`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
  assign new_rec = {(row_cnt_q == '0), row_cnt_q, gate_acc_q, clear_acc_q, ts_row_q};
`else
  assign new_rec = {(row_cnt_q == '0), row_cnt_q, gate_acc_q, clear_acc_q};
`endif

  // Frame/row sequencing: a frame edge always beats a clock edge in the same word.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    row_cnt_d   = row_cnt_q;
    gate_acc_d  = gate_acc_q;
    clear_acc_d = clear_acc_q;
    over_hit_d  = over_hit_q;
    emit        = 1'b0;
    rows_set    = 1'b0;
    glitch_set  = ENABLE && (clk_rises > 3'd1);
`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
    ts_row_d    = ts_row_q;
`endif
    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            row_cnt_d   = '0;
            state_d     = WAIT_CLK;
          end
        end
        WAIT_CLK: begin
          if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            row_cnt_d   = '0;
          end else if (clk_edge) begin
            gate_acc_d  = WIDTH_W'(gate_pop);
            clear_acc_d = WIDTH_W'(clear_pop);
            state_d     = ROW;
`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
            ts_row_d    = ts_q;
`endif
          end
        end
        ROW: begin
          if (frame_edge) begin
            emit        = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            row_cnt_d   = '0;
            state_d     = WAIT_CLK;
          end else if (clk_edge) begin
            emit      = 1'b1;
            row_cnt_d = row_inc[ROW_W-1:0];
            if (row_inc == MAX_ROWS_C) begin
              over_hit_d = 1'b0;
              state_d    = OVER;
            end else begin
              gate_acc_d  = WIDTH_W'(gate_pop);
              clear_acc_d = WIDTH_W'(clear_pop);
`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
              ts_row_d    = ts_q;
`endif
            end
          end else begin
            gate_acc_d  = sat_add(gate_acc_q, gate_pop);
            clear_acc_d = sat_add(clear_acc_q, clear_pop);
          end
        end
        OVER: begin
          if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            row_cnt_d   = '0;
            state_d     = WAIT_CLK;
          end else if (clk_edge && !over_hit_q) begin
            rows_set   = 1'b1;
            over_hit_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output record register and sticky error flags; a set in the same cycle beats CLR_ERR.
  always_comb begin
    rec_valid_d = rec_valid_q;
    rec_data_d  = rec_data_q;
    ovf_set     = 1'b0;
    if (emit) begin
      if (!rec_valid_q || rec.REC_READY) begin
        rec_data_d  = new_rec;
        rec_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (rec_valid_q && rec.REC_READY) begin
      rec_valid_d = 1'b0;
    end
    err_ovf_d    = (err_ovf_q    && !CLR_ERR) || ovf_set;
    err_rows_d   = (err_rows_q   && !CLR_ERR) || rows_set;
    err_glitch_d = (err_glitch_q && !CLR_ERR) || glitch_set;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      prev_clk_q   <= 1'b0;
      prev_frame_q <= 1'b0;
      frame_cnt_q  <= '0;
      row_cnt_q    <= '0;
      gate_acc_q   <= '0;
      clear_acc_q  <= '0;
      over_hit_q   <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_data_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_rows_q   <= 1'b0;
      err_glitch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_clk_q   <= SW_DES[3];
      prev_frame_q <= SW_DES[7];
      frame_cnt_q  <= frame_cnt_d;
      row_cnt_q    <= row_cnt_d;
      gate_acc_q   <= gate_acc_d;
      clear_acc_q  <= clear_acc_d;
      over_hit_q   <= over_hit_d;
      rec_valid_q  <= rec_valid_d;
      rec_data_q   <= rec_data_d;
      err_ovf_q    <= err_ovf_d;
      err_rows_q   <= err_rows_d;
      err_glitch_q <= err_glitch_d;
    end
  end

`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
  // Free-running timestamp and the value captured at row open.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ts_q     <= '0;
      ts_row_q <= '0;
    end else begin
      ts_q     <= ts_q + 16'd1;
      ts_row_q <= ts_row_d;
    end
  end
`endif

  assign rec.REC_DATA  = rec_data_q;
  assign rec.REC_VALID = rec_valid_q;
  assign FRAME_CNT     = frame_cnt_q;
  assign ROW_CNT       = row_cnt_q;
  assign ERR_OVF       = err_ovf_q;
  assign ERR_ROWS      = err_rows_q;
  assign ERR_GLITCH    = err_glitch_q;

endmodule

// File: tb/tb_sw_seq_monitor.sv
// Self-checking bench for sw_seq_monitor: expected records are queued as the
// row-closing words are driven and compared as the DUT hands records over.
// Honors SW_SEQ_MONITOR_TIMESTAMP_EN by ignoring the timestamp LSBs.
module tb_sw_seq_monitor;
  localparam int ROW_W    = 10;
  localparam int WIDTH_W  = 8;
  localparam int MAX_ROWS = 4;
`ifdef SW_SEQ_MONITOR_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif
  localparam int REC_W = 1 + ROW_W + 2*WIDTH_W + TS_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [15:0]      sw_des;
  logic             clr_err;
  logic [15:0]      frame_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             err_ovf, err_rows, err_glitch;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];

  sw_seq_monitor_if #(.DATA_W(REC_W)) rec_if ();

  sw_seq_monitor #(.ROW_W(ROW_W), .WIDTH_W(WIDTH_W), .MAX_ROWS(MAX_ROWS)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .SW_DES(sw_des), .CLR_ERR(clr_err),
    .rec(rec_if), .FRAME_CNT(frame_cnt), .ROW_CNT(row_cnt),
    .ERR_OVF(err_ovf), .ERR_ROWS(err_rows), .ERR_GLITCH(err_glitch)
  );

  // 80 MHz-ish sequencer clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_rec(input bit first, input int row, input int g, input int c);
    return 64'({first, ROW_W'(row), WIDTH_W'(g), WIDTH_W'(c)});
  endfunction

  // Drives one deserialized word for one clock; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] f,
                               input logic [3:0] g, input logic [3:0] cl);
    sw_des = {cl, g, f, c};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_words(input int n, input logic [3:0] g, input logic [3:0] cl);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 4'b0000, g, cl);
  endtask

  task automatic clk_pulse();
    applyStimulus(4'b1100, 4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic frame_pulse();
    applyStimulus(4'b0000, 4'b1100, 4'b0000, 4'b0000);
  endtask

  // Scoreboard side: every completed transfer is matched against the queue head.
  always @(negedge clk) begin
    logic [63:0] got;
    if (rst_n && rec_if.REC_VALID && rec_if.REC_READY) begin
      got = 64'(rec_if.REC_DATA) >> TS_W;
      if (exp_q.size() == 0) checkOutput("unexpected_record", got, 64'hFFFF_FFFF_FFFF_FFFF);
      else                   checkOutput("record", got, exp_q.pop_front());
    end
  end

  initial begin
    rst_n            = 1'b0;
    enable           = 1'b0;
    clr_err          = 1'b0;
    sw_des           = '0;
    rec_if.REC_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("reset_row_cnt", 64'(row_cnt), 64'd0);
    checkOutput("reset_valid", 64'(rec_if.REC_VALID), 64'd0);
    checkOutput("reset_errs", 64'({err_ovf, err_rows, err_glitch}), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    idle_words(2, 4'b0000, 4'b0000);

    // Basic frame: rows of 8 GATE samples each.
    frame_pulse();
    checkOutput("frame_cnt_first", 64'(frame_cnt), 64'd1);
    idle_words(2, 4'b0000, 4'b0000);
    clk_pulse();
    idle_words(2, 4'b1111, 4'b0000);
    idle_words(7, 4'b0000, 4'b0000);
    checkOutput("valid_before_close", 64'(rec_if.REC_VALID), 64'd0);
    exp_q.push_back(mk_rec(1'b1, 0, 8, 0));
    clk_pulse();
    checkOutput("valid_latency", 64'(rec_if.REC_VALID), 64'd1);
    idle_words(2, 4'b1111, 4'b0000);
    idle_words(7, 4'b0000, 4'b0000);
    exp_q.push_back(mk_rec(1'b0, 1, 8, 0));
    clk_pulse();
    checkOutput("row_cnt_two", 64'(row_cnt), 64'd2);
    checkOutput("frame_cnt_one", 64'(frame_cnt), 64'd1);

    // Saturating GATE accumulator and plain CLEAR count.
    idle_words(100, 4'b1111, 4'b0000);
    idle_words(3, 4'b0000, 4'b0011);
    exp_q.push_back(mk_rec(1'b0, 2, 255, 6));
    clk_pulse();
    checkOutput("row_cnt_three", 64'(row_cnt), 64'd3);
    checkOutput("no_errs_sat", 64'({err_ovf, err_rows, err_glitch}), 64'd0);
    idle_words(2, 4'b0000, 4'b0000);
    exp_q.push_back(mk_rec(1'b0, 3, 0, 0));
    frame_pulse();
    checkOutput("frame_cnt_in_row", 64'(frame_cnt), 64'd2);
    checkOutput("row_cnt_frame_reset", 64'(row_cnt), 64'd0);
    idle_words(2, 4'b0000, 4'b0000);

    // Backpressure: held record, dropped second record, error clear.
    rec_if.REC_READY = 1'b0;
    clk_pulse();
    idle_words(3, 4'b0001, 4'b0000);
    exp_q.push_back(mk_rec(1'b1, 0, 3, 0));
    clk_pulse();
    idle_words(3, 4'b0000, 4'b0000);
    clk_pulse();
    checkOutput("ovf_set", 64'(err_ovf), 64'd1);
    checkOutput("held_data", 64'(rec_if.REC_DATA) >> TS_W, mk_rec(1'b1, 0, 3, 0));
    checkOutput("held_valid", 64'(rec_if.REC_VALID), 64'd1);
    rec_if.REC_READY = 1'b1;
    idle_words(2, 4'b0000, 4'b0000);
    clr_err = 1'b1;
    idle_words(1, 4'b0000, 4'b0000);
    clr_err = 1'b0;
    checkOutput("ovf_cleared", 64'(err_ovf), 64'd0);

    // Row limit: back-to-back edges, overrun, restart on next frame.
    exp_q.push_back(mk_rec(1'b0, 2, 0, 0));
    frame_pulse();
    checkOutput("frame_cnt_three", 64'(frame_cnt), 64'd3);
    idle_words(2, 4'b0000, 4'b0000);
    clk_pulse();
    exp_q.push_back(mk_rec(1'b1, 0, 0, 0));
    clk_pulse();
    exp_q.push_back(mk_rec(1'b0, 1, 0, 0));
    clk_pulse();
    exp_q.push_back(mk_rec(1'b0, 2, 0, 0));
    clk_pulse();
    exp_q.push_back(mk_rec(1'b0, 3, 0, 0));
    clk_pulse();
    checkOutput("rows_not_yet", 64'(err_rows), 64'd0);
    checkOutput("row_cnt_max", 64'(row_cnt), 64'd4);
    clk_pulse();
    checkOutput("rows_err", 64'(err_rows), 64'd1);
    checkOutput("no_bubble_ovf", 64'(err_ovf), 64'd0);
    idle_words(2, 4'b0000, 4'b0000);
    frame_pulse();
    checkOutput("frame_cnt_after_over", 64'(frame_cnt), 64'd4);
    checkOutput("row_cnt_after_over", 64'(row_cnt), 64'd0);
    idle_words(1, 4'b0000, 4'b0000);
    clk_pulse();
    idle_words(2, 4'b0000, 4'b0000);
    exp_q.push_back(mk_rec(1'b1, 0, 0, 0));
    clk_pulse();
    idle_words(2, 4'b0000, 4'b0000);

    // Glitchy SW_CLK nibble counts as one boundary.
    exp_q.push_back(mk_rec(1'b0, 1, 0, 0));
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("glitch_err", 64'(err_glitch), 64'd1);
    checkOutput("glitch_row_cnt", 64'(row_cnt), 64'd2);
    clr_err = 1'b1;
    idle_words(1, 4'b0000, 4'b0000);
    clr_err = 1'b0;
    checkOutput("errs_cleared", 64'({err_ovf, err_rows, err_glitch}), 64'd0);
    idle_words(2, 4'b0000, 4'b0000);

    // Frame and clock edges in one word: frame wins, no row opened.
    exp_q.push_back(mk_rec(1'b0, 2, 0, 0));
    applyStimulus(4'b1100, 4'b1100, 4'b0000, 4'b0000);
    checkOutput("frame_cnt_both", 64'(frame_cnt), 64'd5);
    checkOutput("row_cnt_both", 64'(row_cnt), 64'd0);
    idle_words(2, 4'b1111, 4'b0000);
    clk_pulse();
    idle_words(2, 4'b0000, 4'b0000);
    exp_q.push_back(mk_rec(1'b1, 0, 0, 0));
    clk_pulse();
    idle_words(2, 4'b1111, 4'b0000);

    // ENABLE low mid-row drops the row and returns to IDLE.
    enable = 1'b0;
    idle_words(1, 4'b0000, 4'b0000);
    clk_pulse();
    idle_words(1, 4'b0000, 4'b0000);
    enable = 1'b1;
    idle_words(1, 4'b0000, 4'b0000);
    clk_pulse();
    idle_words(2, 4'b0000, 4'b0000);
    checkOutput("frame_cnt_kept", 64'(frame_cnt), 64'd5);
    checkOutput("no_rec_disabled", 64'(rec_if.REC_VALID), 64'd0);
    frame_pulse();
    checkOutput("frame_cnt_reenabled", 64'(frame_cnt), 64'd6);
    clk_pulse();
    idle_words(1, 4'b0000, 4'b0000);
    exp_q.push_back(mk_rec(1'b1, 0, 0, 0));
    clk_pulse();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_words(1, 4'b0000, 4'b0000);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
